// File: rtl/pixel_window3x3.sv
// 3x3 neighbourhood window generator for a raster pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift array holds the
// current neighbourhood. A registered copy of the array is presented on win
// only when the centre is an interior pixel, so win holds between windows.

package pixel_pkg;
   typedef struct packed {
      logic [7:0] red;
      logic [7:0] grn;
      logic [7:0] blu;
   } pixel_t;
endpackage

module pixel_window3x3
   import pixel_pkg::*;
#(
   parameter  int IMG_W = 640,
   parameter  int IMG_H = 480,
   localparam int XW    = $clog2(IMG_W),
   localparam int YW    = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  pixel_t            pix_in,
   input  logic              pix_vld,
   input  logic              sof,
   output pixel_t [0:8]      win,
   output logic              win_vld,
   output logic [XW-1:0]     win_x,
   output logic [YW-1:0]     win_y
);

   // state  | meaning
   // IDLE   | waiting for sof, pixels dropped
   // ACTIVE | accepting pixels of the current frame
   // DONE   | frame complete, pixels dropped until the next sof
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

   state_t        state_q;
   logic [XW-1:0] col_q;
   logic [YW-1:0] row_q;
   pixel_t [0:8]  arr_q;
   pixel_t [0:8]  arr_d;
   pixel_t [0:8]  win_q;
   logic          win_vld_q;
   logic [XW-1:0] win_x_q;
   logic [YW-1:0] win_y_q;

   pixel_t        lbuf0_q [0:IMG_W-1];
   pixel_t        lbuf1_q [0:IMG_W-1];
   pixel_t        lb0_rd;
   pixel_t        lb1_rd;

   logic          accept;
   logic          restart;
   logic          emit;
   logic [XW-1:0] col_cur;
   logic [YW-1:0] row_cur;

   // Reads see the contents from before this cycle's write.
   assign lb0_rd = lbuf0_q[col_cur];
   assign lb1_rd = lbuf1_q[col_cur];

   // Acceptance, effective coordinate (sof forces 0,0) and the shifted array.
   always_comb begin
      restart = pix_vld & sof;
      accept  = pix_vld & (sof | (state_q == ACTIVE));
      col_cur = restart ? '0 : col_q;
      row_cur = restart ? '0 : row_q;
      emit    = accept & (col_cur >= XW'(2)) & (row_cur >= YW'(2));
      arr_d   = arr_q;
      for (int r = 0; r < 3; r++) begin
         arr_d[3*r]     = arr_q[3*r + 1];
         arr_d[3*r + 1] = arr_q[3*r + 2];
      end
      arr_d[2] = lb1_rd;
      arr_d[5] = lb0_rd;
      arr_d[8] = pix_in;
   end

   // Line buffer chain: row above moves up into lbuf1, new pixel into lbuf0.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         lbuf0_q[col_cur] <= pix_in;
         lbuf1_q[col_cur] <= lb0_rd;
      end
   end

   // Frame FSM, raster counters, shift array and registered window outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         arr_q     <= '0;
         win_q     <= '0;
         win_vld_q <= 1'b0;
         win_x_q   <= '0;
         win_y_q   <= '0;
      end else begin
         win_vld_q <= emit;
         if (accept) begin
            arr_q <= arr_d;
            if (emit) begin
               win_q   <= arr_d;
               win_x_q <= col_cur - XW'(1);
               win_y_q <= row_cur - YW'(1);
            end
            if (col_cur == COL_LAST) begin
               col_q <= '0;
               if (row_cur == ROW_LAST) begin
                  row_q   <= '0;
                  state_q <= DONE;
               end else begin
                  row_q   <= row_cur + YW'(1);
                  state_q <= ACTIVE;
               end
            end else begin
               col_q   <= col_cur + XW'(1);
               row_q   <= row_cur;
               state_q <= ACTIVE;
            end
         end
      end
   end

   assign win     = win_q;
   assign win_vld = win_vld_q;
   assign win_x   = win_x_q;
   assign win_y   = win_y_q;

endmodule

// File: tb/tb_pixel_window3x3.sv
// Directed bench for pixel_window3x3 on a 4x4 image.
// Pixel (c,r) of a frame with offset base carries base + r*16 + c on all channels.

module tb_pixel_window3x3;
   import pixel_pkg::*;

   logic         clk;
   logic         rst;
   logic         pix_vld;
   logic         sof;
   pixel_t       pix_in;
   pixel_t [0:8] win;
   logic         win_vld;
   logic [1:0]   win_x;
   logic [1:0]   win_y;

   int n_chk = 0;
   int n_err = 0;
   int n_win = 0;

   pixel_window3x3 #(.IMG_W(4), .IMG_H(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .pix_in  (pix_in),
      .pix_vld (pix_vld),
      .sof     (sof),
      .win     (win),
      .win_vld (win_vld),
      .win_x   (win_x),
      .win_y   (win_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (win_vld === 1'b1) n_win++;

   typedef struct packed {
      logic       vld;
      logic       sof;
      logic [7:0] val;
      logic       exp_vld;
      logic [1:0] ex;
      logic [1:0] ey;
      logic [7:0] w0;
      logic [7:0] w4;
      logic [7:0] w8;
   } vec_t;

   function automatic pixel_t px(input logic [7:0] v);
      px = '{red: v, grn: v, blu: v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [7:0] val, input logic r);
      pix_vld = v;
      sof     = s;
      pix_in  = px(val);
      rst     = r;
      @(posedge clk);
      #1;
      pix_vld = 1'b0;
      sof     = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic check_win(input string name, input int cx, input int cy, input logic [7:0] base);
      pixel_t [0:8] exp;
      for (int k = 0; k < 9; k++)
         exp[k] = px(base + 8'((cy - 1 + k / 3) * 16 + (cx - 1 + k % 3)));
      n_chk++;
      if (win_vld !== 1'b1 || win !== exp || win_x !== 2'(cx) || win_y !== 2'(cy)) begin
         n_err++;
         $display("FAIL %s: got vld=%b x=%0d y=%0d w0=%h w4=%h w8=%h expected vld=1 x=%0d y=%0d w0=%h w4=%h w8=%h",
                  name, win_vld, win_x, win_y, win[0], win[4], win[8], cx, cy, exp[0], exp[4], exp[8]);
      end
   endtask

   // Sends pixel indices 0..n_pix-1 of a frame (sof on index 0), checking each edge.
   task automatic send_frame_part(input string name, input logic [7:0] base, input int n_pix, input bit throttle);
      for (int i = 0; i < n_pix; i++) begin
         int c = i % 4;
         int r = i / 4;
         if (throttle) begin
            int gaps = $urandom_range(0, 2);
            repeat (gaps) begin
               step(1'b0, 1'b0, 8'hEE, 1'b0);
               chk({name, "_gap_vld"}, 32'(win_vld), 32'd0);
            end
         end
         step(1'b1, i == 0, base + 8'(r * 16 + c), 1'b0);
         if (c >= 2 && r >= 2) check_win({name, "_win"}, c - 1, r - 1, base);
         else chk({name, "_nowin"}, 32'(win_vld), 32'd0);
      end
   endtask

   task automatic run_frame(input string name, input logic [7:0] base, input bit throttle);
      int start = n_win;
      send_frame_part(name, base, 16, throttle);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk({name, "_tail_vld"}, 32'(win_vld), 32'd0);
      chk({name, "_count"}, 32'(n_win - start), 32'd4);
   endtask

   // Pixels with pix_vld but no sof; none may produce a window.
   task automatic send_dropped(input string name, input logic [7:0] base, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         step(1'b1, 1'b0, base + 8'((i / 4) * 16 + (i % 4)), 1'b0);
         chk(name, 32'(win_vld), 32'd0);
      end
   endtask

   vec_t tbl [17];
   int   start;

   initial begin
      // Normal frame: pixel stream in raster order, observation after each edge.
      tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 8'h01, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 8'h02, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[3]  = '{1'b1, 1'b0, 8'h03, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[4]  = '{1'b1, 1'b0, 8'h10, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[5]  = '{1'b1, 1'b0, 8'h11, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[6]  = '{1'b1, 1'b0, 8'h12, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[7]  = '{1'b1, 1'b0, 8'h13, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 1'b0, 8'h20, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[9]  = '{1'b1, 1'b0, 8'h21, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[10] = '{1'b1, 1'b0, 8'h22, 1'b1, 2'd1, 2'd1, 8'h00, 8'h11, 8'h22};
      tbl[11] = '{1'b1, 1'b0, 8'h23, 1'b1, 2'd2, 2'd1, 8'h01, 8'h12, 8'h23};
      tbl[12] = '{1'b1, 1'b0, 8'h30, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[13] = '{1'b1, 1'b0, 8'h31, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};
      tbl[14] = '{1'b1, 1'b0, 8'h32, 1'b1, 2'd1, 2'd2, 8'h10, 8'h21, 8'h32};
      tbl[15] = '{1'b1, 1'b0, 8'h33, 1'b1, 2'd2, 2'd2, 8'h11, 8'h22, 8'h33};
      tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00};

      rst = 1'b1; pix_vld = 1'b0; sof = 1'b0; pix_in = '0;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_chk++;
      if (win_vld !== 1'b0 || win_x !== 2'd0 || win_y !== 2'd0 || win !== '0) begin
         n_err++;
         $display("FAIL reset_state: got vld=%b x=%0d y=%0d w4=%h expected all zero", win_vld, win_x, win_y, win[4]);
      end

      // Table-driven normal frame.
      start = n_win;
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].vld, tbl[i].sof, tbl[i].val, 1'b0);
         chk("tbl_vld", 32'(win_vld), 32'(tbl[i].exp_vld));
         if (tbl[i].exp_vld)
            chk("tbl_win", {win_x, win_y, win[0].red, win[4].red, win[8].red, 4'h0},
                {tbl[i].ex, tbl[i].ey, tbl[i].w0, tbl[i].w4, tbl[i].w8, 4'h0});
      end
      chk("tbl_count", 32'(n_win - start), 32'd4);

      // Outputs hold across idle cycles.
      repeat (3) step(1'b0, 1'b0, 8'h55, 1'b0);
      chk("hold_w4", 32'(win[4]), 32'(px(8'h22)));
      chk("hold_w0", 32'(win[0]), 32'(px(8'h11)));
      chk("hold_xy", {30'd0, win_x} * 4 + 32'(win_y), 32'd10);

      // Post-frame pixels without sof are dropped, then a +0x80 frame.
      send_dropped("post_frame_drop", 8'h70, 0, 3);
      send_frame_part("frame80", 8'h80, 11, 1'b0);
      chk("frame80_first_w4", 32'(win[4]), 32'(px(8'h91)));
      send_frame_part("frame80b", 8'h80, 0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      run_frame("frame80_full", 8'h80, 1'b0);

      // Throttled input, same contents as the normal frame.
      run_frame("throttle", 8'h00, 1'b1);
      run_frame("throttle2", 8'h00, 1'b1);

      // Drop before frame after a reset.
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("reset2_vld", 32'(win_vld), 32'd0);
      send_dropped("pre_frame_drop", 8'h00, 0, 5);
      run_frame("after_drop", 8'h00, 1'b0);

      // sof restart at A's pixel (1,2): B starts there.
      start = n_win;
      send_frame_part("frameA", 8'h40, 9, 1'b0);
      run_frame("frameB", 8'h60, 1'b0);
      chk("restart_count", 32'(n_win - start), 32'd4);

      // Reset mid-frame on pixel (3,2).
      send_frame_part("frameC", 8'hA0, 11, 1'b0);
      step(1'b1, 1'b0, 8'hA0 + 8'h23, 1'b1);
      chk("midreset_vld", 32'(win_vld), 32'd0);
      start = n_win;
      send_dropped("midreset_drop", 8'hA0, 12, 4);
      chk("midreset_drop_count", 32'(n_win - start), 32'd0);
      run_frame("after_midreset", 8'h20, 1'b0);

      // rst together with pix_vld&sof: pixel dropped, FSM stays idle.
      step(1'b1, 1'b1, 8'h00, 1'b1);
      chk("rst_sof_vld", 32'(win_vld), 32'd0);
      start = n_win;
      send_dropped("rst_sof_drop", 8'h00, 1, 15);
      chk("rst_sof_count", 32'(n_win - start), 32'd0);
      run_frame("final", 8'h05, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_window3x3.md
Name: pixel_window3x3

Overview:
- Upstream neighbour of the per-channel compare-exchange stage in the median-filter path.
- Converts a raster pixel stream into 3x3 neighbourhood windows using two on-chip line buffers and a 3x3 shift-register array.
- Each window presents nine pixel_pkg::pixel_t values in parallel, ready for the compare-exchange sorting network.
- No backpressure: the camera stream cannot stall.

Parameters:
IMG_W, 640, active pixels per line (>=3)
IMG_H, 480, active lines per frame (>=3)
XW, $clog2(IMG_W), column coordinate width (derived, not overridden)
YW, $clog2(IMG_H), row coordinate width (derived, not overridden)

Ports:
clk      input   1               system clock, all logic on rising edge
rst      input   1               synchronous active-high reset
pix_in   input   pixel_t         incoming pixel (red/grn/blu)
pix_vld  input   1               pix_in valid this cycle
sof      input   1               start of frame; qualified by pix_vld, marks pixel (0,0)
win      output  pixel_t [0:8]   window, row-major: [0]=top-left, [4]=centre, [8]=bottom-right
win_vld  output  1               win/win_x/win_y valid, single-cycle pulse per window
win_x    output  XW              centre column of win
win_y    output  YW              centre row of win

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - On rst: state=IDLE, col=0, row=0, win_vld=0, win_x=0, win_y=0, win all zero.
  - Line buffer contents are not reset; validity is gated by row count.
- States:
  - IDLE: waiting for a frame.
  - ACTIVE: accepting pixels.
  - DONE: frame complete.
- Accepted pixel: pix_vld=1 in ACTIVE, or pix_vld&sof in any state.
- IDLE transitions:
  - pix_vld&sof: accept as (0,0), go ACTIVE.
  - pix_vld without sof: dropped.
- ACTIVE, per accepted pixel:
  - Write pix_in into line buffer at col.
  - Shift the 3x3 array left by one column. The new right column is {lbuf1[col], lbuf0[col], pix_in}, top to bottom.
  - Line buffers form a chain: lbuf1 <= old lbuf0[col]; lbuf0 <= pix_in.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - The accepted pixel at (IMG_W-1, IMG_H-1) moves state to DONE.
- DONE transitions:
  - pix_vld without sof: dropped, no window.
  - pix_vld&sof: new frame, pixel taken as (0,0), go ACTIVE.
- sof in ACTIVE (restart):
  - The pixel is treated as (0,0) of a new frame.
  - col and row restart.
  - No window is produced from the aborted frame after this cycle.
- Window emission:
  - Accepting pixel (c,r) with c>=2 and r>=2 registers win_vld=1 on the next clk edge.
  - win_x=c-1, win_y=r-1. win holds pixels (c-2..c, r-2..r).
  - Latency is 1 cycle from the accepting edge.
  - Yields (IMG_W-2)*(IMG_H-2) windows per frame. No border windows: border pixels are never centres.
  - Windows never span a line wrap. Columns 0 and 1 of each row only prime the array.
- Idle cycles:
  - win_vld=0 when no qualifying pixel was accepted in the previous cycle.
  - win, win_x and win_y hold their last values.
  - Gaps in pix_vld do not alter window contents.
- Arithmetic:
  - Pixels pass through unmodified, per channel.
  - Coordinates are unsigned; col and row never exceed IMG_W-1 / IMG_H-1.
- rst mid-frame:
  - Next cycle win_vld=0, state=IDLE.
  - Pixels before the next sof are dropped.
- rst and pix_vld&sof in the same cycle: rst wins and the pixel is dropped.
- Line buffers: single-port write, read of the same address in the same cycle. They are inferable as RAM, with read-before-write semantics required.

Test Plan:
- Normal frame:
  - Setup: IMG_W=4, IMG_H=4; pixel (c,r) has all channels = r*16+c; sof on first pixel; pix_vld continuous.
  - Expect 4 win_vld pulses, centres (1,1),(2,1),(1,2),(2,2).
  - First pulse 1 cycle after pixel (2,2) is accepted, with win[0]=0x00, win[4]=0x11, win[8]=0x22.
  - Last pulse: win[0]=0x11, win[8]=0x33.
- Throttled input:
  - Same frame with pix_vld toggling 1,0,0,1,... at random.
  - Expect window contents identical to the normal-frame scenario.
  - win_vld only ever follows an accepting cycle.
- Drop before frame:
  - 5 pixels with pix_vld=1, sof=0 after reset, then a full frame.
  - Expect exactly 4 windows, with values as in the normal-frame scenario.
- Post-frame drop then next frame:
  - After the frame completes, 3 extra pixels without sof: no win_vld.
  - Then a second frame with values +0x80: 4 windows, first with win[4]=0x91.
- sof restart:
  - Assert sof on pixel (1,2) of frame A, then send a full frame B.
  - Expect no further A windows; B produces exactly 4 windows.
- Reset mid-frame:
  - Assert rst on the cycle pixel (3,2) is presented.
  - Expect win_vld=0 the next cycle.
  - Following pixels without sof are dropped; the next full frame yields 4 correct windows.
